// File: rtl/addroundkey_pipe.sv
// AddRoundKey pipeline stage: local round-key store, XOR of each accepted
// state block with the key chosen by round number (forward/inverse order).
// Ports: clk, rst (async, active-low); key_we/key_addr/key_data write the
//   key store; in_valid/in_ready/in_state/in_round/in_inv form the input
//   handshake; out_valid/out_ready/out_state/out_round/out_err the output.
// Build option: define ADDROUNDKEY_SKID_EN for a 2-entry output buffer with
//   a registered in_ready; otherwise a 1-entry buffer is used.
module addroundkey_pipe #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_we,
    input  logic [RW-1:0] key_addr,
    input  logic [127:0]  key_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_state,
    input  logic [RW-1:0] in_round,
    input  logic          in_inv,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_state,
    output logic [RW-1:0] out_round,
    output logic          out_err
);

    logic [127:0] keys [NR+1];

    logic [RW:0]  rnd_ext;
    logic [RW:0]  k_idx;
    logic         oor;
    logic [127:0] key_sel;
    logic [127:0] res_state;
    logic         push;
    logic         pop;

    // Index math is one bit wider than the round field so NR - round
    // cannot wrap for any in-range round.
    always_comb begin
        rnd_ext = {1'b0, in_round};
        oor     = rnd_ext > (RW+1)'(NR);
        k_idx   = in_inv ? (RW+1)'(NR) - rnd_ext : rnd_ext;
        key_sel = '0;
        for (int i = 0; i <= NR; i++) begin
            if (k_idx == (RW+1)'(i)) key_sel = keys[i];
        end
        res_state = oor ? in_state : (in_state ^ key_sel);
    end

    // The XOR above reads the current register contents, so a write to
    // the same index in the same cycle only affects later blocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i <= NR; i++) keys[i] <= '0;
        end else if (key_we) begin
            for (int i = 0; i <= NR; i++) begin
                if (key_addr == RW'(i)) keys[i] <= key_data;
            end
        end
    end

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

`ifdef ADDROUNDKEY_SKID_EN

    logic [1:0]    cnt;
    logic [1:0]    cnt_nxt;
    logic          rdy_q;
    logic          ld_head;
    logic          ld_skid;
    logic          head_from_skid;
    logic [127:0]  sk_state;
    logic [RW-1:0] sk_round;
    logic          sk_err;

    // Head registers drive the outputs; the skid entry only fills when
    // the head is stalled, and pushes are impossible at cnt == 2.
    always_comb begin
        cnt_nxt        = cnt;
        ld_head        = 1'b0;
        ld_skid        = 1'b0;
        head_from_skid = 1'b0;
        case (cnt)
            2'd0: begin
                if (push) begin
                    ld_head = 1'b1;
                    cnt_nxt = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    ld_head = 1'b1;
                end else if (push) begin
                    ld_skid = 1'b1;
                    cnt_nxt = 2'd2;
                end else if (pop) begin
                    cnt_nxt = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_from_skid = 1'b1;
                    cnt_nxt        = 2'd1;
                end
            end
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= 2'd0;
            rdy_q     <= 1'b1;
            out_state <= '0;
            out_round <= '0;
            out_err   <= 1'b0;
            sk_state  <= '0;
            sk_round  <= '0;
            sk_err    <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            rdy_q <= cnt_nxt < 2'd2;
            if (ld_head) begin
                out_state <= res_state;
                out_round <= in_round;
                out_err   <= oor;
            end else if (head_from_skid) begin
                out_state <= sk_state;
                out_round <= sk_round;
                out_err   <= sk_err;
            end
            if (ld_skid) begin
                sk_state <= res_state;
                sk_round <= in_round;
                sk_err   <= oor;
            end
        end
    end

    assign out_valid = cnt != 2'd0;
    assign in_ready  = rdy_q;

`else

    // Single entry: a full buffer still accepts when it drains this cycle.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_state <= '0;
            out_round <= '0;
            out_err   <= 1'b0;
        end else if (push) begin
            out_valid <= 1'b1;
            out_state <= res_state;
            out_round <= in_round;
            out_err   <= oor;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_addroundkey_pipe.sv
// Self-checking bench for addroundkey_pipe: vector table, hand sequences
// for stall/key-write/reset corners, and randomized traffic vs. a model.
module tb_addroundkey_pipe;

    localparam int NR = 10;
    localparam int RW = 4;
`ifdef ADDROUNDKEY_SKID_EN
    localparam int STALL_ACC = 2;
`else
    localparam int STALL_ACC = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          key_we;
    logic [RW-1:0] key_addr;
    logic [127:0]  key_data;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  in_state;
    logic [RW-1:0] in_round;
    logic          in_inv;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_state;
    logic [RW-1:0] out_round;
    logic          out_err;

    addroundkey_pipe #(.NR(NR), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .key_we(key_we), .key_addr(key_addr), .key_data(key_data),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .in_round(in_round), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_state(out_state), .out_round(out_round), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] s;
        logic [3:0]   r;
        logic         e;
    } exp_t;

    typedef struct {
        logic [127:0] st;
        logic [3:0]   rnd;
        logic         inv;
        logic [127:0] exp_st;
        logic         exp_err;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pops  = 0;

    logic [127:0] mk [0:NR];
    exp_t         sb [$];
    logic         lat_pend  = 1'b0;
    logic         hold_pend = 1'b0;
    logic [127:0] h_s;
    logic [3:0]   h_r;
    logic         h_e;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic exp_t ref_model(input logic [127:0] st,
                                       input logic [3:0] r,
                                       input logic inv);
        exp_t x;
        int   ri;
        int   k;
        ri  = int'(r);
        x.r = r;
        if (ri > NR) begin
            x.s = st;
            x.e = 1'b1;
        end else begin
            k   = inv ? NR - ri : ri;
            x.s = st ^ mk[k];
            x.e = 1'b0;
        end
        return x;
    endfunction

    // Scoreboard monitor: transfers, latency and stall stability.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            cyc++;
            if (lat_pend) chk("latency", {127'd0, out_valid}, 128'd1);
            lat_pend = 1'b0;
            if (hold_pend) begin
                chk("hold_valid", {127'd0, out_valid}, 128'd1);
                chk("hold_state", out_state, h_s);
                chk("hold_round", {124'd0, out_round}, {124'd0, h_r});
                chk("hold_err", {127'd0, out_err}, {127'd0, h_e});
            end
            hold_pend = 1'b0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_output: got %h want none",
                             out_state);
                end else begin
                    e = sb.pop_front();
                    chk("sb_state", out_state, e.s);
                    chk("sb_round", {124'd0, out_round}, {124'd0, e.r});
                    chk("sb_err", {127'd0, out_err}, {127'd0, e.e});
                    pops++;
                end
            end
            if (out_valid && !out_ready) begin
                hold_pend = 1'b1;
                h_s = out_state;
                h_r = out_round;
                h_e = out_err;
            end
            if (in_valid && in_ready) begin
                sb.push_back(ref_model(in_state, in_round, in_inv));
                lat_pend = 1'b1;
            end
            if (key_we && int'(key_addr) <= NR) mk[key_addr] = key_data;
        end
    end

    task automatic wkey(input int a, input logic [127:0] d);
        key_we   = 1'b1;
        key_addr = RW'(a);
        key_data = d;
        @(posedge clk);
        #1 key_we = 1'b0;
    endtask

    // Leaves in_valid high so back-to-back calls stream without gaps.
    task automatic send(input logic [127:0] st, input logic [3:0] r,
                        input logic inv);
        bit ok = 0;
        in_valid = 1'b1;
        in_state = st;
        in_round = r;
        in_inv   = inv;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 want 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    vec_t         vt [8];
    logic [127:0] xs;
    logic [7:0]   b;
    int           c0;
    int           p0;
    int           acc;

    initial begin
        xs = 128'h0123456789abcdef_fedcba9876543210;
        vt[0] = '{128'd0, 4'd3, 1'b0, {16{8'h03}}, 1'b0};
        vt[1] = '{128'd0, 4'd3, 1'b1, {16{8'h07}}, 1'b0};
        vt[2] = '{xs, 4'd11, 1'b0, xs, 1'b1};
        vt[3] = '{128'd0, 4'd10, 1'b1, 128'd0, 1'b0};
        vt[4] = '{128'd0, 4'd0, 1'b1, {16{8'h0a}}, 1'b0};
        vt[5] = '{{16{8'hff}}, 4'd10, 1'b0, {16{8'hf5}}, 1'b0};
        vt[6] = '{xs, 4'd15, 1'b1, xs, 1'b1};
        vt[7] = '{{16{8'ha5}}, 4'd1, 1'b0, {16{8'ha4}}, 1'b0};

        for (int i = 0; i <= NR; i++) mk[i] = '0;
        rst = 1'b0;
        key_we = 1'b0; key_addr = '0; key_data = '0;
        in_valid = 1'b0; in_state = '0; in_round = '0; in_inv = 1'b0;
        out_ready = 1'b1;

        #1;
        chk("rst_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_state", out_state, 128'd0);
        chk("rst_round", {124'd0, out_round}, 128'd0);
        chk("rst_err", {127'd0, out_err}, 128'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i <= NR; i++) begin
            b = 8'(i);
            wkey(i, {16{b}});
        end

        foreach (vt[i]) begin
            in_valid = 1'b1;
            in_state = vt[i].st;
            in_round = vt[i].rnd;
            in_inv   = vt[i].inv;
            @(negedge clk);
            chk("vec_ready", {127'd0, in_ready}, 128'd1);
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
            chk("vec_valid", {127'd0, out_valid}, 128'd1);
            chk("vec_state", out_state, vt[i].exp_st);
            chk("vec_err", {127'd0, out_err}, {127'd0, vt[i].exp_err});
            @(posedge clk);
            #1;
        end

        c0 = cyc;
        p0 = pops;
        for (int i = 0; i < 8; i++) send({4{$urandom}}, 4'(i + 2), 1'(i));
        in_valid = 1'b0;
        chk("stream_cycles", 128'(cyc - c0), 128'd8);
        @(negedge clk);
        #1 chk("stream_pops", 128'(pops - p0), 128'd8);
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_state = {4{$urandom}};
            in_round = 4'(c);
            in_inv   = 1'b0;
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("stall_accepted", 128'(acc), 128'(STALL_ACC));
        @(negedge clk);
        chk("stall_ready_low", {127'd0, in_ready}, 128'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        idle(4);
        chk("stall_drained", 128'(sb.size()), 128'd0);

        key_we   = 1'b1;
        key_addr = 4'd4;
        key_data = {16{8'hc3}};
        in_valid = 1'b1;
        in_state = '0;
        in_round = 4'd4;
        in_inv   = 1'b0;
        @(negedge clk);
        chk("rbw_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk);
        #1 key_we = 1'b0;
        @(negedge clk);
        chk("rbw_old_key", out_state, {16{8'h04}});
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("rbw_new_key", out_state, {16{8'hc3}});
        @(posedge clk);
        #1;
        wkey(12, {128{1'b1}});
        for (int i = 0; i <= NR; i++) send(xs, 4'(i), 1'b0);
        in_valid = 1'b0;
        idle(3);

        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            in_state  = {$urandom, $urandom, $urandom, $urandom};
            in_round  = 4'($urandom % 16);
            in_inv    = 1'($urandom);
            key_we    = ($urandom % 10) == 0;
            key_addr  = 4'($urandom % 16);
            key_data  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        key_we    = 1'b0;
        out_ready = 1'b1;
        idle(4);
        chk("rand_drained", 128'(sb.size()), 128'd0);

        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_state = {4{$urandom}};
            in_round = 4'(c + 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", {127'd0, out_valid}, 128'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", {127'd0, out_valid}, 128'd0);
        chk("mid_rst_state", out_state, 128'd0);
        chk("mid_rst_round", {124'd0, out_round}, 128'd0);
        chk("mid_rst_err", {127'd0, out_err}, 128'd0);
        sb.delete();
        for (int i = 0; i <= NR; i++) mk[i] = '0;
        lat_pend  = 1'b0;
        hold_pend = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk);
        #1;
        send({16{8'ha5}}, 4'd5, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("keys_cleared", out_state, {16{8'ha5}});
        chk("keys_cleared_err", {127'd0, out_err}, 128'd0);
        idle(2);
        chk("final_drained", 128'(sb.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
